// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter sharing one combinational 16-bit ALU
//
// Grants one of two requesters, holds its operands on the ALU for EXEC_CYCLES
// cycles, captures result/flags and returns them to the owning port.
// Optional feature: define ALU_ARB_RR_EN for round-robin tie-breaking
// (default build: fixed priority, port 0 wins every tie).
//
// Ports:
//   clk_100, rst_n                      clock, async active-low reset
//   req{0,1}_valid/ready/ctrl/acc/b     request channels
//   rsp{0,1}_valid/ready/data/z/n/err   response channels
//   alu_ctrl/acc/b (out), alu_out/z (in) ALU pins
//   busy                                high whenever not IDLE

module alu_arbiter #(
    parameter int                DATA_W      = 16,
    parameter int                CTRL_W      = 5,
    parameter int                EXEC_CYCLES = 2,
    parameter logic [CTRL_W-1:0] NOP_CODE    = 5'b11000,
    parameter logic [CTRL_W-1:0] MAX_CODE    = 5'b11000
) (
    input  logic              clk_100,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [DATA_W-1:0] req0_acc,
    input  logic [DATA_W-1:0] req0_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_z,
    output logic              rsp0_n,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [DATA_W-1:0] req1_acc,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_z,
    output logic              rsp1_n,
    output logic              rsp1_err,

    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_acc,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_z,

    output logic              busy
);

    localparam logic [CTRL_W-1:0] ZERO_CODE = '0;
    localparam logic [3:0]        CNT_INIT  = 4'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [CTRL_W-1:0]   r_ctrl;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_b;
    logic                r_owner;
    logic                r_err;
    logic                r_nop;
    logic [3:0]          r_cnt;
    logic [DATA_W-1:0]   r_data;
    logic                r_z;
    logic                r_n;

    logic                w_prio0;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_accept;
    logic                w_rsp_hs;
    logic [CTRL_W-1:0]   w_sel_ctrl;
    logic [DATA_W-1:0]   w_sel_acc;
    logic [DATA_W-1:0]   w_sel_b;
    logic                w_illegal;
    logic                w_is_nop;

    // Arbitration: w_prio0 says whether port 0 wins a tie.
`ifdef ALU_ARB_RR_EN
    logic r_last_grant;

    // Reset to 1 so that port 0 takes the first tie.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant1;
        end
    end

    assign w_prio0 = r_last_grant;
`else
    assign w_prio0 = 1'b1;
`endif

    assign w_grant0 = req0_valid & (~req1_valid | w_prio0);
    assign w_grant1 = req1_valid & ~w_grant0;
    assign w_accept = (r_state == S_IDLE) & (w_grant0 | w_grant1);
    assign w_rsp_hs = (r_state == S_RESP) & (r_owner ? rsp1_ready : rsp0_ready);

    assign w_sel_ctrl = w_grant1 ? req1_ctrl : req0_ctrl;
    assign w_sel_acc  = w_grant1 ? req1_acc  : req0_acc;
    assign w_sel_b    = w_grant1 ? req1_b    : req0_b;
    assign w_illegal  = (w_sel_ctrl > MAX_CODE);
    assign w_is_nop   = (w_sel_ctrl == NOP_CODE);

    // State register
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)      w_next = S_EXEC;
            S_EXEC: if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP: if (w_rsp_hs)      w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    // Operand latch, execution counter and result capture
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl  <= NOP_CODE;
            r_acc   <= '0;
            r_b     <= '0;
            r_owner <= 1'b0;
            r_err   <= 1'b0;
            r_nop   <= 1'b0;
            r_cnt   <= 4'd0;
            r_data  <= '0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
        end else begin
            if (w_accept) begin
                // Illegal codes never reach the ALU; ZERO keeps it quiet.
                r_ctrl  <= w_illegal ? ZERO_CODE : w_sel_ctrl;
                r_acc   <= w_sel_acc;
                r_b     <= w_sel_b;
                r_owner <= w_grant1;
                r_err   <= w_illegal;
                r_nop   <= w_is_nop;
                r_cnt   <= CNT_INIT;
            end else if (r_state == S_EXEC) begin
                if (r_cnt == 4'd0) begin
                    // NOP leaves the ALU bus floating, so its output is not
                    // sampled; illegal ops report the same constant result.
                    if (r_nop || r_err) begin
                        r_data <= '0;
                        r_z    <= 1'b1;
                        r_n    <= 1'b0;
                    end else begin
                        r_data <= alu_out;
                        r_z    <= alu_z;
                        r_n    <= alu_out[DATA_W-1];
                    end
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    // Output logic
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_data  = '0;
        rsp0_z     = 1'b0;
        rsp0_n     = 1'b0;
        rsp0_err   = 1'b0;
        rsp1_data  = '0;
        rsp1_z     = 1'b0;
        rsp1_n     = 1'b0;
        rsp1_err   = 1'b0;
        alu_ctrl   = NOP_CODE;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                req0_ready = w_grant0;
                req1_ready = w_grant1;
            end
            S_EXEC: begin
                alu_ctrl = r_ctrl;
            end
            S_RESP: begin
                if (r_owner) begin
                    rsp1_valid = 1'b1;
                    rsp1_data  = r_data;
                    rsp1_z     = r_z;
                    rsp1_n     = r_n;
                    rsp1_err   = r_err;
                end else begin
                    rsp0_valid = 1'b1;
                    rsp0_data  = r_data;
                    rsp0_z     = r_z;
                    rsp0_n     = r_n;
                    rsp0_err   = r_err;
                end
            end
            default: ;
        endcase
    end

    assign alu_acc = r_acc;
    assign alu_b   = r_b;

endmodule
